// File: rtl/apb_uart_requester.sv
// APB requester for the UART peripheral port: turns single valid/ready
// commands into SETUP/ACCESS transfers with a wait-state timeout.
module apb_uart_requester #(
    parameter int ADDR_W  = 12,
    parameter int WDATA_W = 8,
    parameter int RDATA_W = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [ADDR_W-1:0]  cmd_addr,
    input  logic [WDATA_W-1:0] cmd_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_write,
    output logic [RDATA_W-1:0] rsp_rdata,
    output logic               rsp_timeout,
    output logic               busy,
    output logic               PSEL,
    output logic               PENABLE,
    output logic               PWRITE,
    output logic [ADDR_W-1:0]  PADDR,
    output logic [WDATA_W-1:0] PWDATA,
    input  logic               PREADY,
    input  logic [RDATA_W-1:0] PRDATA
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LAST_I);

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_wait;
    logic               r_psel;
    logic               r_penable;
    logic               r_pwrite;
    logic [ADDR_W-1:0]  r_paddr;
    logic [WDATA_W-1:0] r_pwdata;
    logic               r_rsp_valid;
    logic               r_rsp_write;
    logic [RDATA_W-1:0] r_rsp_rdata;
    logic               r_rsp_timeout;
    logic               w_expire;

    // Abort on the TIMEOUT-th low-PREADY ACCESS cycle; PREADY wins a tie.
    assign w_expire = (TIMEOUT != 0) && (r_wait == LAST);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state       <= S_IDLE;
            r_wait        <= '0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_write   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_pwrite <= cmd_write;
                        r_paddr  <= cmd_addr;
                        r_pwdata <= cmd_wdata;
                        r_wait   <= '0;
                        r_psel   <= 1'b1;
                        r_state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (PREADY || w_expire) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_write   <= r_pwrite;
                        r_rsp_timeout <= !PREADY;
                        r_rsp_rdata   <= (PREADY && !r_pwrite) ? PRDATA : '0;
                        r_state       <= S_RESP;
                    end else if (r_wait != '1) begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                default: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign cmd_ready   = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign PSEL        = r_psel;
    assign PENABLE     = r_penable;
    assign PWRITE      = r_pwrite;
    assign PADDR       = r_paddr;
    assign PWDATA      = r_pwdata;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_write   = r_rsp_write;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_uart_requester.sv
// Directed bench for apb_uart_requester with TIMEOUT = 8.
module tb_apb_uart_requester;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [11:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic        rsp_timeout;
    logic        busy;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [11:0] PADDR;
    logic [7:0]  PWDATA;
    logic        PREADY;
    logic [31:0] PRDATA;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 PCLK = ~PCLK;

    apb_uart_requester #(.TIMEOUT(8)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
        .rsp_timeout(rsp_timeout), .busy(busy),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA),
        .PREADY(PREADY), .PRDATA(PRDATA)
    );

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    // Accept one command, insert nw wait states, stop when rsp_valid.
    task automatic issue(input logic w, input logic [11:0] a,
                         input logic [7:0] d, input int nw,
                         input logic [31:0] rd,
                         output int lat, output int ps,
                         output int pe);
        int seen;
        seen = 0;
        ps = 0;
        pe = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        PREADY    = 1'b0;
        PRDATA    = rd;
        rsp_ready = 1'b0;
        chk("pre_accept_ready", cmd_ready, 1);
        tick();
        lat = 1;
        cmd_valid = 1'b0;
        if (PSEL) ps++;
        if (PENABLE) pe++;
        while (!rsp_valid && lat < 40) begin
            if (PENABLE) begin
                PREADY = (seen == nw);
                seen++;
            end else begin
                PREADY = 1'b0;
            end
            tick();
            lat++;
            if (PSEL) ps++;
            if (PENABLE) pe++;
        end
        PREADY = 1'b0;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("consume_valid", rsp_valid, 0);
        chk("consume_ready", cmd_ready, 1);
    endtask

    initial begin
        int lat, ps, pe;
        int n_acc, n_rsp, n_hi;
        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        PREADY    = 1'b0;
        PRDATA    = '0;
        repeat (3) tick();

        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwdata", PWDATA, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        PRESETn = 1'b1;
        tick();

        // zero-wait write; PRDATA junk must not leak into rsp_rdata
        issue(1, 12'h104, 8'hA5, 0, 32'hDEADBEEF, lat, ps, pe);
        chk("wr_lat", lat, 3);
        chk("wr_psel_cyc", ps, 2);
        chk("wr_pen_cyc", pe, 1);
        chk("wr_pwrite", PWRITE, 1);
        chk("wr_paddr", PADDR, 12'h104);
        chk("wr_pwdata", PWDATA, 8'hA5);
        chk("wr_rdata", rsp_rdata, 0);
        chk("wr_tmo", rsp_timeout, 0);
        chk("wr_rsp_write", rsp_write, 1);
        chk("wr_busy", busy, 1);
        consume();
        chk("wr_hold_paddr", PADDR, 12'h104);

        // read with 3 wait states
        issue(0, 12'h108, 8'h00, 3, 32'h0000005A, lat, ps, pe);
        chk("rd3_lat", lat, 6);
        chk("rd3_psel_cyc", ps, 5);
        chk("rd3_rdata", rsp_rdata, 32'h5A);
        chk("rd3_rsp_write", rsp_write, 0);
        chk("rd3_tmo", rsp_timeout, 0);
        consume();

        // timeout: PREADY never rises
        issue(0, 12'h110, 8'h00, 100, 32'h12345678, lat, ps, pe);
        chk("tmo_lat", lat, 10);
        chk("tmo_psel_cyc", ps, 9);
        chk("tmo_pen_cyc", pe, 8);
        chk("tmo_flag", rsp_timeout, 1);
        chk("tmo_rdata", rsp_rdata, 0);
        chk("tmo_psel_low", PSEL, 0);
        consume();

        // PREADY on the 8th ACCESS cycle completes normally
        issue(0, 12'h114, 8'h00, 7, 32'hCAFE0001, lat, ps, pe);
        chk("edge_lat", lat, 10);
        chk("edge_flag", rsp_timeout, 0);
        chk("edge_rdata", rsp_rdata, 32'hCAFE0001);
        consume();

        // response backpressure with a pending command
        issue(0, 12'h118, 8'h00, 1, 32'h00000077, lat, ps, pe);
        chk("bp_lat", lat, 4);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 12'h10C;
        cmd_wdata = 8'h3C;
        PREADY    = 1'b1;
        PRDATA    = 32'h99999999;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", rsp_valid, 1);
            chk("bp_rdata", rsp_rdata, 32'h77);
            chk("bp_write", rsp_write, 0);
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_psel", PSEL, 0);
            chk("bp_paddr", PADDR, 12'h118);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp_idle_ready", cmd_ready, 1);
        chk("bp_idle_psel", PSEL, 0);
        tick();
        cmd_valid = 1'b0;
        chk("bp_accept_psel", PSEL, 1);
        chk("bp_accept_paddr", PADDR, 12'h10C);
        tick();
        tick();
        chk("bp2_valid", rsp_valid, 1);
        chk("bp2_write", rsp_write, 1);
        chk("bp2_rdata", rsp_rdata, 0);
        consume();

        // back-to-back alternating write/read, zero wait
        n_acc = 0;
        n_rsp = 0;
        n_hi  = 0;
        rsp_ready = 1'b1;
        PREADY    = 1'b1;
        for (int t = 0; t < 16; t++) begin
            logic acc;
            acc = 1'b0;
            if (n_acc < 4 && cmd_ready) begin
                cmd_valid = 1'b1;
                cmd_write = (n_acc % 2 == 0);
                cmd_addr  = 12'h100 + 12'(n_acc);
                cmd_wdata = 8'h10 + 8'(n_acc);
                PRDATA    = 32'hC0DE0000 + 32'(n_acc);
                acc = 1'b1;
            end else begin
                cmd_valid = 1'b0;
            end
            tick();
            if (acc) n_acc++;
            if (PSEL) n_hi++;
            if (rsp_valid) begin
                logic ew;
                ew = (n_rsp % 2 == 0);
                chk("b2b_order_write", rsp_write, ew);
                chk("b2b_rdata", rsp_rdata,
                    ew ? 32'h0 : 32'hC0DE0000 + 32'(n_rsp));
                n_rsp++;
            end
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        PREADY    = 1'b0;
        chk("b2b_accepts", n_acc, 4);
        chk("b2b_rsps", n_rsp, 4);
        chk("b2b_psel_high", n_hi, 8);
        chk("b2b_idle", cmd_ready, 1);

        // asynchronous reset while in ACCESS
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 12'h120;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("rst_mid_pen_pre", PENABLE, 1);
        #2;
        PRESETn = 1'b0;
        #1;
        chk("rst_mid_psel", PSEL, 0);
        chk("rst_mid_pen", PENABLE, 0);
        chk("rst_mid_valid", rsp_valid, 0);
        chk("rst_mid_ready", cmd_ready, 1);
        tick();
        PRESETn = 1'b1;
        PREADY  = 1'b1;
        repeat (3) tick();
        chk("post_rst_valid", rsp_valid, 0);
        chk("post_rst_ready", cmd_ready, 1);
        chk("post_rst_busy", busy, 0);
        issue(0, 12'h124, 8'h00, 0, 32'h0BADF00D, lat, ps, pe);
        chk("post_rst_lat", lat, 3);
        chk("post_rst_rdata", rsp_rdata, 32'h0BADF00D);
        consume();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/apb_uart_requester.md
# apb_uart_requester

APB requester (initiator) that drives the peripheral-side APB bus of the UART block from a simple valid/ready command channel. It issues single 8-bit write or 32-bit read transfers, sequencing the SETUP and ACCESS phases and honouring PREADY wait states. It bounds each transfer with a wait-state timeout and returns each result on a valid/ready response channel. It sits between a CPU-side or test-sequencer command source and the UART's PSEL/PENABLE/PWRITE/PADDR/PWDATA/PREADY/PRDATA port group.

## Interface
- ADDR_W, 12, PADDR width. Bits [11:8] select the peripheral; bits [7:0] select the register.
- WDATA_W, 8, PWDATA width.
- RDATA_W, 32, PRDATA width.
- TIMEOUT, 255, number of ACCESS cycles with PREADY low before the transfer is aborted. 0 disables the timeout.

Ports (name, direction, width, meaning):
- PCLK, in, 1, single clock. All state is updated on the rising edge.
- PRESETn, in, 1, reset. Asynchronous, active-low.
- cmd_valid, in, 1, command present.
- cmd_ready, out, 1, command accepted on an edge where cmd_valid && cmd_ready.
- cmd_write, in, 1, 1 = write, 0 = read.
- cmd_addr, in, ADDR_W, transfer address.
- cmd_wdata, in, WDATA_W, write data.
- rsp_valid, out, 1, response present.
- rsp_ready, in, 1, response consumed on an edge where rsp_valid && rsp_ready.
- rsp_write, out, 1, echo of cmd_write for this transfer.
- rsp_rdata, out, RDATA_W, captured PRDATA. Zero for writes and for timed-out transfers.
- rsp_timeout, out, 1, transfer was aborted by the timeout.
- busy, out, 1, state is not IDLE.
- PSEL, out, 1, APB select.
- PENABLE, out, 1, APB enable.
- PWRITE, out, 1, APB direction.
- PADDR, out, ADDR_W, APB address.
- PWDATA, out, WDATA_W, APB write data.
- PREADY, in, 1, completer ready.
- PRDATA, in, RDATA_W, completer read data.

## Operation
FSM states: IDLE, SETUP, ACCESS, RESP. All APB and response outputs are registered. cmd_ready is decoded as state == IDLE.

- **IDLE**
  - cmd_ready = 1; PSEL = 0, PENABLE = 0.
  - On accept, latch cmd_write, cmd_addr, cmd_wdata into PWRITE, PADDR, PWDATA; clear the wait counter; go to SETUP.
- **SETUP**
  - PSEL = 1, PENABLE = 0.
  - Lasts exactly one cycle, then go to ACCESS.
- **ACCESS**
  - PSEL = 1, PENABLE = 1. PADDR, PWRITE and PWDATA are held stable.
  - PREADY = 1 at the edge: capture PRDATA into rsp_rdata for reads (0 for writes); rsp_timeout = 0; go to RESP.
  - PREADY = 0 at the edge: increment the wait counter (width clog2(TIMEOUT+1), saturating).
  - Abort when TIMEOUT != 0 and PREADY = 0 on the TIMEOUT-th ACCESS cycle. Then rsp_timeout = 1, rsp_rdata = 0, go to RESP.
  - PREADY = 1 on that same edge means normal completion, not timeout.
- **RESP**
  - PSEL = 0, PENABLE = 0, rsp_valid = 1.
  - rsp_write, rsp_rdata and rsp_timeout are held stable until rsp_ready.
  - On consume, go to IDLE.

Other rules:
- After a transfer, PADDR, PWRITE and PWDATA keep their last values until the next accept.
- PREADY and PRDATA are ignored outside ACCESS.
- Reset values: state IDLE, so cmd_ready = 1 and busy = 0. PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_write, rsp_rdata, rsp_timeout and the wait counter are all 0.
- Reset asserted mid-transfer: all outputs take their reset values immediately (asynchronously) and the in-flight command is dropped with no response.

## Timing
- Command accepted at edge k:
  - PSEL rises after edge k.
  - PENABLE rises after edge k+1.
  - With zero wait states, PREADY is sampled at edge k+2 and rsp_valid rises after edge k+2.
- Accept-to-rsp_valid latency is 3 + W edges, where W is the number of wait states.
- A timed-out transfer raises rsp_valid after edge k+1+TIMEOUT.
- PSEL is high for exactly 2 + W cycles per transfer.
- Back-to-back throughput, with cmd_valid and rsp_ready held high, is one transfer per 4 + W cycles. PSEL is low for exactly 2 cycles (RESP, IDLE) between transfers.
- cmd_ready is low from the edge after accept until the edge that consumes the response.

## Test plan
- **Zero-wait write:** command write, addr 0x104, data 0xA5.
  - PSEL high 2 cycles, PENABLE high 1 cycle, PWRITE = 1, PADDR = 0x104, PWDATA = 0xA5.
  - rsp_valid 3 edges after accept, with rsp_rdata = 0 and rsp_timeout = 0.
- **Read with 3 wait states:** command read, addr 0x108; PREADY raised on the 4th ACCESS cycle with PRDATA = 0x0000005A.
  - rsp_rdata = 0x0000005A, rsp_write = 0, rsp_valid 6 edges after accept.
- **Timeout, TIMEOUT = 8:**
  - PREADY held at 0: PSEL and PENABLE drop after 8 ACCESS cycles; rsp_timeout = 1, rsp_rdata = 0.
  - Repeat with PREADY = 1 exactly on the 8th ACCESS cycle: normal completion, rsp_timeout = 0.
- **Response backpressure:** rsp_ready low for 5 cycles during RESP.
  - rsp fields stable, cmd_ready = 0, PSEL = 0, a pending cmd_valid is not accepted.
  - Accept occurs on the first IDLE cycle after consume.
- **Back-to-back:** 4 alternating write/read commands, cmd_valid and rsp_ready held at 1, zero wait.
  - Exactly 4 transfers in 16 cycles, PSEL low 2 cycles between transfers, responses in command order.
- **Reset mid-ACCESS:** PRESETn driven low while in ACCESS.
  - PSEL, PENABLE and rsp_valid go to 0 without waiting for a PCLK edge.
  - After release: cmd_ready = 1, no stale response, and the next command completes normally.
